dma_pcis_buf_sched: RTL and testbench
=====================================

Name: dma_pcis_buf_sched

Overview:
- Burst scheduler for the 16-entry x 512-bit single-port scratch buffer behind the DMA PCIS AXI4 slave (post register slice).
- Accepts AW and AR address handshakes, arbitrates round-robin, and owns the buffer port for exactly one whole burst at a time.
- Generates per-beat buffer enables/addresses plus all AXI ready/valid/response control.
- Data buses (wdata to buffer, buffer dout to rdata) are wired outside this block.

Parameters:
- ADDR_W, 4, buffer index width (depth 2^ADDR_W = 16)
- ID_W, 6, AXI ID width
- LEN_W, 8, AXI len width

Ports:
- clk  in  1  clock
- pipe_rst_n  in  1  asynchronous, active-low reset
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awid  in  ID_W  write ID
- awaddr_idx  in  ADDR_W  awaddr[9:6], start beat index
- awlen  in  LEN_W  beats-1
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wlast  in  1  last write beat
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bid  out  ID_W  response ID
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arid  in  ID_W  read ID
- araddr_idx  in  ADDR_W  araddr[9:6]
- arlen  in  LEN_W  beats-1
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rlast  out  1  last read beat
- rid  out  ID_W  read ID
- rresp  out  2  00 OKAY, 10 SLVERR
- buf_we  out  1  buffer write strobe (comb)
- buf_re  out  1  buffer read strobe; buffer dout register loads only on buf_re, 1-cycle latency
- buf_addr  out  ADDR_W  buffer index for buf_we/buf_re

Behaviour:
- Reset values (all outputs):
  - State IDLE; rr_ptr = write-favoured.
  - awready, arready, wready, bvalid, rvalid, rlast, buf_we, buf_re = 0.
  - bid, rid, bresp, rresp, buf_addr = 0.
- Reset mid-burst: immediate return to IDLE, outstanding burst discarded, no response issued.
- States: IDLE, WR, WRESP, RD.
- IDLE arbitration:
  - awready = sel_wr, arready = sel_rd, both combinational.
  - Only awvalid set -> write selected. Only arvalid set -> read selected.
  - Both set -> the channel not granted last (rr_ptr). rr_ptr flips on each grant.
  - Handshake in cycle T: capture id, start idx, len; clear beat counter; enter WR/RD at T+1.
  - IDLE lasts at least one cycle between bursts.
- WR:
  - wready = 1.
  - Each wvalid beat: buf_we = 1 (comb), buf_addr = (start + beat) mod 16, beat++.
  - awlen > 15: SLVERR; all beats accepted, buf_we held 0.
  - Beat count > awlen+1 before wlast: extra beats accepted, buf_we = 0, error flagged.
  - wlast on beat count != awlen+1: error flagged.
  - On wlast beat -> WRESP.
- WRESP:
  - bvalid = 1 from the cycle after wlast; bid = captured id.
  - bresp = 10 if any error was flagged, else 00.
  - bvalid held until bready -> IDLE.
- RD:
  - Issue condition: beats remain and (!rvalid || rready).
  - On issue: buf_re = 1, buf_addr = (start + issued) mod 16.
  - rvalid set the cycle after buf_re; rid = captured id.
  - rlast = 1 on beat arlen; rdata held stable while rvalid && !rready.
  - Full throughput: one beat per cycle with rready held high.
  - arlen > 15: buf_re held 0, arlen+1 beats returned with rresp = 10 (rdata undefined). Otherwise rresp = 00.
  - Last beat rvalid && rready -> IDLE, with rvalid/rlast deasserted the same edge.
- Address arithmetic: ADDR_W-bit, wraps modulo 16. The beat counter is LEN_W+1 bits, so it never overflows for len = 255.
- An AW or AR arriving during the other burst waits; valid stays high and ready stays 0.

Test Plan:
- Write at idx 0, awlen=1 (D0, D1, wlast on beat 2) -> buf_we at addr 0 then 1, bvalid the next cycle, bresp=00, bid=awid; then read idx 0, arlen=1 -> buf_re addr 0,1, rvalid 1 cycle after each, rlast on second beat, rid=arid.
- awvalid and arvalid both high from reset, three times back-to-back -> grant order W, R, W; no buf_we and buf_re in the same cycle.
- Read idx 14, arlen=3 with rready low 2 cycles mid-burst -> buf_addr 14, 15, 0, 1; no buf_re while rvalid && !rready; exactly 4 beats, rlast on the 4th.
- awlen=16, 17 beats with wlast on the 17th -> buf_we never asserted, bresp=10; then arlen=20 -> 21 beats with rresp=10, buf_re never asserted.
- wlast on beat 2 of awlen=3 -> bresp=10, return to IDLE; next AW accepted normally with bresp=00.
- pipe_rst_n low during beat 2 of a read burst -> all outputs 0 asynchronously; after release a new AR is granted and starts at its own start idx.

Source files
------------

// File: rtl/dma_pcis_buf_sched.sv
// Burst scheduler for the 16-entry scratch buffer behind the DMA PCIS slave.
// Grants one whole AW or AR burst at a time and drives buffer strobes/AXI control.
module dma_pcis_buf_sched #(
    parameter int ADDR_W = 4,
    parameter int ID_W   = 6,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              pipe_rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr_idx,
    input  logic [LEN_W-1:0]  awlen,
    input  logic              wvalid,
    output logic              wready,
    input  logic              wlast,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr_idx,
    input  logic [LEN_W-1:0]  arlen,
    output logic              rvalid,
    input  logic              rready,
    output logic              rlast,
    output logic [ID_W-1:0]   rid,
    output logic [1:0]        rresp,
    output logic              buf_we,
    output logic              buf_re,
    output logic [ADDR_W-1:0] buf_addr
);

    typedef enum logic [1:0] {IDLE, WR, WRESP, RD} state_t;

    localparam int CNT_W = LEN_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'((1 << ADDR_W) - 1);

    state_t            state;
    state_t            state_n;
    logic              rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  beat;
    logic [CNT_W-1:0]  len_cnt;
    logic              err;
    logic              len_big;
    logic              sel_wr;
    logic              sel_rd;
    logic              wr_beat;
    logic              over;
    logic              rd_issue;
    logic              rd_done;

    assign len_cnt = {1'b0, len};
    assign len_big = (len > MAX_LEN);

    // rr_ptr = 0 favours the write channel on a tie
    assign sel_wr = pipe_rst_n && (state == IDLE) && awvalid
                    && (!arvalid || !rr_ptr);
    assign sel_rd = pipe_rst_n && (state == IDLE) && arvalid
                    && (!awvalid || rr_ptr);

    assign wr_beat  = (state == WR) && wvalid;
    assign over     = (beat > len_cnt);
    assign rd_issue = (state == RD) && (beat <= len_cnt)
                      && (!rvalid || rready);
    assign rd_done  = (state == RD) && rvalid && rready && rlast;

    assign awready  = sel_wr;
    assign arready  = sel_rd;
    assign wready   = (state == WR);
    assign buf_we   = wr_beat && !len_big && !over;
    assign buf_re   = rd_issue && !len_big;
    assign buf_addr = (buf_we || buf_re) ? start + beat[ADDR_W-1:0]
                                         : '0;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (sel_wr)
                    state_n = WR;
                else if (sel_rd)
                    state_n = RD;
            end
            WR: begin
                if (wr_beat && wlast)
                    state_n = WRESP;
            end
            WRESP: begin
                if (bready)
                    state_n = IDLE;
            end
            RD: begin
                if (rd_done)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            cur_id <= '0;
            start  <= '0;
            len    <= '0;
            beat   <= '0;
            err    <= 1'b0;
            bvalid <= 1'b0;
            bid    <= '0;
            bresp  <= 2'b00;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rid    <= '0;
            rresp  <= 2'b00;
        end else begin
            state <= state_n;
            if (sel_wr || sel_rd) begin
                rr_ptr <= sel_wr;
                cur_id <= sel_wr ? awid : arid;
                start  <= sel_wr ? awaddr_idx : araddr_idx;
                len    <= sel_wr ? awlen : arlen;
                beat   <= '0;
                err    <= (sel_wr ? awlen : arlen) > MAX_LEN;
            end
            if (wr_beat) begin
                // saturate so a runaway burst never wraps back into range
                if (beat != '1)
                    beat <= beat + 1'b1;
                if (wlast ? (beat != len_cnt) : over)
                    err <= 1'b1;
                if (wlast) begin
                    bvalid <= 1'b1;
                    bid    <= cur_id;
                    bresp  <= (err || beat != len_cnt) ? 2'b10 : 2'b00;
                end
            end
            if (state == WRESP && bready)
                bvalid <= 1'b0;
            if (rd_issue) begin
                beat   <= beat + 1'b1;
                rvalid <= 1'b1;
                rlast  <= (beat == len_cnt);
                rid    <= cur_id;
                rresp  <= len_big ? 2'b10 : 2'b00;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_pcis_buf_sched.sv
// Directed bench for dma_pcis_buf_sched: handshakes, arbitration,
// wrap-around addressing, error bursts and mid-burst reset.
module tb_dma_pcis_buf_sched;

    logic       clk = 1'b0;
    logic       pipe_rst_n;
    logic       awvalid, awready;
    logic [5:0] awid;
    logic [3:0] awaddr_idx;
    logic [7:0] awlen;
    logic       wvalid, wready, wlast;
    logic       bvalid, bready;
    logic [5:0] bid;
    logic [1:0] bresp;
    logic       arvalid, arready;
    logic [5:0] arid;
    logic [3:0] araddr_idx;
    logic [7:0] arlen;
    logic       rvalid, rready, rlast;
    logic [5:0] rid;
    logic [1:0] rresp;
    logic       buf_we, buf_re;
    logic [3:0] buf_addr;

    int passed = 0;
    int total  = 0;
    int g, overlap, nre, nbeat, nwe, stall, bad;
    logic       gr[3];
    logic [3:0] addrs[4];

    dma_pcis_buf_sched dut (
        .clk(clk), .pipe_rst_n(pipe_rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid),
        .awaddr_idx(awaddr_idx), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid),
        .araddr_idx(araddr_idx), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .rid(rid), .rresp(rresp),
        .buf_we(buf_we), .buf_re(buf_re), .buf_addr(buf_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        pipe_rst_n = 1'b0;
        awvalid = 0; awid = 0; awaddr_idx = 0; awlen = 0;
        wvalid = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr_idx = 0; arlen = 0; rready = 0;

        // reset values, with requests pending
        awvalid = 1; arvalid = 1;
        #2;
        chk("rst_awready", 32'(awready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_ctl", 32'({wready, bvalid, rvalid, rlast, buf_we, buf_re}), 0);
        chk("rst_fields", 32'({bid, rid, bresp, rresp, buf_addr}), 0);
        awvalid = 0; arvalid = 0;
        @(posedge clk);
        #3 pipe_rst_n = 1;
        tick();

        // basic write idx 0, awlen 1
        awvalid = 1; awaddr_idx = 0; awlen = 1; awid = 6'h05;
        #1;
        chk("t1_awready", 32'(awready), 1);
        chk("t1_arready", 32'(arready), 0);
        tick();
        awvalid = 0; wvalid = 1; wlast = 0;
        #1;
        chk("t1_we0", 32'({wready, buf_we, buf_addr}), 32'({2'b11, 4'd0}));
        tick();
        wlast = 1;
        #1;
        chk("t1_we1", 32'({buf_we, buf_addr}), 32'({1'b1, 4'd1}));
        tick();
        wvalid = 0; wlast = 0;
        #1;
        chk("t1_b", 32'({bvalid, bresp, bid, buf_we}),
            32'({1'b1, 2'b00, 6'h05, 1'b0}));
        bready = 1;
        tick();
        bready = 0;
        #1;
        chk("t1_bdone", 32'(bvalid), 0);

        // basic read idx 0, arlen 1
        arvalid = 1; araddr_idx = 0; arlen = 1; arid = 6'h09;
        #1;
        chk("t1_arready", 32'(arready), 1);
        tick();
        arvalid = 0; rready = 1;
        #1;
        chk("t1_re0", 32'({buf_re, buf_addr, rvalid}), 32'({1'b1, 4'd0, 1'b0}));
        tick();
        chk("t1_re1", 32'({buf_re, buf_addr, rvalid, rlast, rid}),
            32'({1'b1, 4'd1, 1'b1, 1'b0, 6'h09}));
        tick();
        chk("t1_rlast", 32'({buf_re, rvalid, rlast, rresp}),
            32'({1'b0, 1'b1, 1'b1, 2'b00}));
        tick();
        chk("t1_rdone", 32'({rvalid, rlast}), 0);
        rready = 0;

        // arbitration from reset: both channels requesting
        pipe_rst_n = 0;
        #2;
        pipe_rst_n = 1;
        tick();
        g = 0; overlap = 0;
        awvalid = 1; awlen = 0; awaddr_idx = 3; awid = 6'h01;
        arvalid = 1; arlen = 0; araddr_idx = 4; arid = 6'h02;
        wvalid = 1; wlast = 1; bready = 1; rready = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (buf_we && buf_re) overlap++;
            if (awvalid && awready) begin
                if (g < 3) gr[g] = 1'b1;
                g++;
            end
            if (arvalid && arready) begin
                if (g < 3) gr[g] = 1'b0;
                g++;
            end
            tick();
            if (g >= 3) begin
                awvalid = 0; arvalid = 0;
            end
        end
        wvalid = 0; wlast = 0; bready = 0; rready = 0;
        chk("t2_ngrants", 32'(g), 3);
        chk("t2_order", 32'({gr[0], gr[1], gr[2]}), 32'(3'b101));
        chk("t2_overlap", 32'(overlap), 0);

        // wrapping read with mid-burst backpressure
        arvalid = 1; araddr_idx = 14; arlen = 3; arid = 6'h2A;
        #1;
        chk("t3_arready", 32'(arready), 1);
        tick();
        arvalid = 0;
        nre = 0; nbeat = 0; stall = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            rready = !(c == 2 || c == 3);
            #1;
            if (buf_re) begin
                if (nre < 4) addrs[nre] = buf_addr;
                nre++;
                if (rvalid && !rready) stall++;
            end
            if (rvalid && rready) begin
                if (rlast !== (nbeat == 3)) bad++;
                if (rid !== 6'h2A) bad++;
                nbeat++;
            end
            tick();
        end
        rready = 0;
        chk("t3_nre", 32'(nre), 4);
        chk("t3_addr0", 32'(addrs[0]), 14);
        chk("t3_addr1", 32'(addrs[1]), 15);
        chk("t3_addr2", 32'(addrs[2]), 0);
        chk("t3_addr3", 32'(addrs[3]), 1);
        chk("t3_nbeat", 32'(nbeat), 4);
        chk("t3_stall", 32'(stall), 0);
        chk("t3_rlast_rid", 32'(bad), 0);

        // oversize write: awlen 16, 17 beats
        awvalid = 1; awaddr_idx = 5; awlen = 16; awid = 6'h07;
        #1;
        chk("t4_awready", 32'(awready), 1);
        tick();
        awvalid = 0;
        nwe = 0;
        for (int b = 0; b < 17; b++) begin
            wvalid = 1; wlast = (b == 16);
            #1;
            if (buf_we) nwe++;
            tick();
        end
        wvalid = 0; wlast = 0;
        #1;
        chk("t4_nwe", 32'(nwe), 0);
        chk("t4_b", 32'({bvalid, bresp, bid}), 32'({1'b1, 2'b10, 6'h07}));
        bready = 1;
        tick();
        bready = 0;

        // oversize read: arlen 20, 21 beats
        arvalid = 1; araddr_idx = 0; arlen = 20; arid = 6'h15;
        #1;
        chk("t4_arready", 32'(arready), 1);
        tick();
        arvalid = 0; rready = 1;
        nre = 0; nbeat = 0; bad = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (buf_re) nre++;
            if (rvalid && rready) begin
                if (rresp !== 2'b10) bad++;
                nbeat++;
            end
            tick();
        end
        rready = 0;
        chk("t4_rbeats", 32'(nbeat), 21);
        chk("t4_nre", 32'(nre), 0);
        chk("t4_rresp", 32'(bad), 0);

        // early wlast, then a clean burst
        awvalid = 1; awaddr_idx = 8; awlen = 3; awid = 6'h03;
        tick();
        awvalid = 0; wvalid = 1; wlast = 0;
        tick();
        wlast = 1;
        tick();
        wvalid = 0; wlast = 0;
        #1;
        chk("t5_b", 32'({bvalid, bresp, bid}), 32'({1'b1, 2'b10, 6'h03}));
        bready = 1;
        tick();
        bready = 0;
        #1;
        chk("t5_bdone", 32'(bvalid), 0);
        awvalid = 1; awaddr_idx = 9; awlen = 0; awid = 6'h04;
        #1;
        chk("t5_awready", 32'(awready), 1);
        tick();
        awvalid = 0; wvalid = 1; wlast = 1;
        #1;
        chk("t5_we", 32'({buf_we, buf_addr}), 32'({1'b1, 4'd9}));
        tick();
        wvalid = 0; wlast = 0;
        #1;
        chk("t5_b2", 32'({bvalid, bresp, bid}), 32'({1'b1, 2'b00, 6'h04}));
        bready = 1;
        tick();
        bready = 0;

        // reset during beat 2 of a read
        arvalid = 1; araddr_idx = 2; arlen = 3; arid = 6'h0B;
        tick();
        arvalid = 0; rready = 1;
        tick();
        tick();
        chk("t6_midburst", 32'({rvalid, buf_re}), 32'(2'b11));
        #2;
        pipe_rst_n = 0;
        #1;
        chk("t6_rst_ctl", 32'({rvalid, rlast, buf_re, buf_we, bvalid, arready}), 0);
        chk("t6_rst_fields", 32'({rid, rresp, buf_addr}), 0);
        #2;
        pipe_rst_n = 1;
        tick();
        arvalid = 1; araddr_idx = 7; arlen = 0; arid = 6'h0C;
        #1;
        chk("t6_arready", 32'(arready), 1);
        tick();
        arvalid = 0;
        #1;
        chk("t6_re", 32'({buf_re, buf_addr}), 32'({1'b1, 4'd7}));
        tick();
        chk("t6_r", 32'({rvalid, rlast, rid, rresp}),
            32'({1'b1, 1'b1, 6'h0C, 2'b00}));
        tick();
        chk("t6_rdone", 32'(rvalid), 0);
        rready = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
